// File: rtl/matrix_storage_arbiter_if.sv
`default_nettype none
// ==========================================================================
// matrix_storage_arbiter_if : client request/access bundle for the matrix RAM
// arbiter; client k occupies slice k of every flattened vector. Rev 1.0
// ==========================================================================
interface matrix_storage_arbiter_if #(
   parameter int N_CLIENTS = 3,
   parameter int ADDR_W    = 8,
   parameter int DATA_W    = 32
);
   logic [N_CLIENTS-1:0]        i_req;
   logic [N_CLIENTS-1:0]        i_we;
   logic [N_CLIENTS*ADDR_W-1:0] i_addr;
   logic [N_CLIENTS*DATA_W-1:0] i_wdata;
   logic [N_CLIENTS-1:0]        o_gnt;
   logic [N_CLIENTS-1:0]        o_rvalid;
   logic [DATA_W-1:0]           o_rdata;
   logic                        o_err;
   logic                        o_busy;

   modport master (
      output i_req, i_we, i_addr, i_wdata,
      input  o_gnt, o_rvalid, o_rdata, o_err, o_busy
   );

   modport slave (
      input  i_req, i_we, i_addr, i_wdata,
      output o_gnt, o_rvalid, o_rdata, o_err, o_busy
   );
endinterface
`default_nettype wire

// File: rtl/matrix_storage_arbiter.sv
`default_nettype none
// ==========================================================================
// matrix_storage_arbiter : N-client burst arbiter owning a single-port matrix
// RAM. Define MATRIX_ARB_RR_EN for round-robin, else fixed priority. Rev 1.0
// ==========================================================================
module matrix_storage_arbiter #(
   parameter int N_CLIENTS = 3,
   parameter int ADDR_W    = 8,
   parameter int DATA_W    = 32,
   parameter int DEPTH     = 256,
   parameter int MAX_BURST = 16
) (
   input wire clk,
   input wire rst_n,
   matrix_storage_arbiter_if.slave bus
);
   localparam int OWN_W = $clog2(N_CLIENTS);
   localparam int CNT_W = $clog2(MAX_BURST + 1);
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY    = 2'd1,
      RELEASE = 2'd2
   } state_t;

   state_t               state, state_nxt;
   logic [OWN_W-1:0]     owner, owner_nxt;
   logic [OWN_W-1:0]     last_owner, last_owner_nxt;
   logic [OWN_W-1:0]     winner;
   logic [CNT_W-1:0]     burst_cnt, burst_cnt_nxt;
   logic [N_CLIENTS-1:0] gnt, gnt_nxt;
   logic [N_CLIENTS-1:0] win_onehot, own_onehot;
   logic [N_CLIENTS-1:0] rvalid;
   logic [DATA_W-1:0]    rdata;
   logic                 err;

   logic                 any_req, others_req, access, in_range;
   logic                 owner_req, owner_we;
   logic [ADDR_W-1:0]    owner_addr;
   logic [DATA_W-1:0]    owner_wdata;

   logic [DATA_W-1:0]    mem [DEPTH];

   assign any_req  = |bus.i_req;
   assign in_range = (int'(owner_addr) < DEPTH);

   // Only the current owner's slice ever reaches the RAM.
   always_comb begin
      owner_req   = 1'b0;
      owner_we    = 1'b0;
      owner_addr  = '0;
      owner_wdata = '0;
      others_req  = 1'b0;
      own_onehot  = '0;
      for (int k = 0; k < N_CLIENTS; k++) begin
         if (owner == OWN_W'(k)) begin
            owner_req     = bus.i_req[k];
            owner_we      = bus.i_we[k];
            owner_addr    = bus.i_addr[k*ADDR_W +: ADDR_W];
            owner_wdata   = bus.i_wdata[k*DATA_W +: DATA_W];
            own_onehot[k] = 1'b1;
         end else if (bus.i_req[k]) begin
            others_req = 1'b1;
         end
      end
   end

   always_comb begin
      winner     = '0;
      win_onehot = '0;
`ifdef MATRIX_ARB_RR_EN
      // Scan offsets from farthest to nearest so the nearest requester above
      // last_owner is the final assignment.
      for (int i = N_CLIENTS; i >= 1; i--) begin
         for (int k = 0; k < N_CLIENTS; k++) begin
            if ((k == (int'(last_owner) + i) % N_CLIENTS) && bus.i_req[k]) begin
               winner = OWN_W'(k);
            end
         end
      end
`else
      for (int k = N_CLIENTS - 1; k >= 0; k--) begin
         if (bus.i_req[k]) begin
            winner = OWN_W'(k);
         end
      end
`endif
      for (int k = 0; k < N_CLIENTS; k++) begin
         win_onehot[k] = (winner == OWN_W'(k));
      end
   end

   always_comb begin
      state_nxt      = state;
      owner_nxt      = owner;
      last_owner_nxt = last_owner;
      burst_cnt_nxt  = burst_cnt;
      gnt_nxt        = gnt;
      access         = 1'b0;
      case (state)
         IDLE: begin
            if (any_req) begin
               state_nxt     = BUSY;
               owner_nxt     = winner;
               gnt_nxt       = win_onehot;
               burst_cnt_nxt = '0;
            end
         end
         BUSY: begin
            if (!owner_req) begin
               state_nxt = RELEASE;
               gnt_nxt   = '0;
            end else begin
               access = 1'b1;
               if (burst_cnt != CNT_W'(MAX_BURST)) begin
                  burst_cnt_nxt = burst_cnt + CNT_W'(1);
               end
               // The capping access itself completes; the owner only yields
               // when somebody else is actually waiting.
               if ((burst_cnt >= CNT_W'(MAX_BURST - 1)) && others_req) begin
                  state_nxt = RELEASE;
                  gnt_nxt   = '0;
               end
            end
         end
         RELEASE: begin
            state_nxt      = IDLE;
            last_owner_nxt = owner;
         end
         default: begin
            state_nxt = IDLE;
            gnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         owner      <= '0;
         last_owner <= OWN_W'(N_CLIENTS - 1);
         burst_cnt  <= '0;
         gnt        <= '0;
         rvalid     <= '0;
         rdata      <= '0;
         err        <= 1'b0;
      end else begin
         state      <= state_nxt;
         owner      <= owner_nxt;
         last_owner <= last_owner_nxt;
         burst_cnt  <= burst_cnt_nxt;
         gnt        <= gnt_nxt;
         err        <= access && !in_range;
         rvalid     <= (access && !owner_we) ? own_onehot : '0;
         if (access && !owner_we) begin
            rdata <= in_range ? mem[owner_addr[IDX_W-1:0]] : '0;
         end
      end
   end

   // Storage array is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (access && owner_we && in_range) begin
         mem[owner_addr[IDX_W-1:0]] <= owner_wdata;
      end
   end

   assign bus.o_gnt    = gnt;
   assign bus.o_rvalid = rvalid;
   assign bus.o_rdata  = rdata;
   assign bus.o_err    = err;
   assign bus.o_busy   = (state == BUSY);

endmodule
`default_nettype wire

// File: doc/matrix_storage_arbiter.md
Name: matrix_storage_arbiter

Overview:
Parametrised N-client arbiter with integrated single-port synchronous matrix RAM, replacing the static enable-based storage mux plus standalone storage. Clients (input, display, calculator and future ones) request ownership, receive a registered one-hot grant, then issue burst reads/writes. It adds fairness (burst cap), per-client read-valid routing and out-of-range detection.

Parameters:
N_CLIENTS, 3, number of requesting clients (2..8)
ADDR_W, 8, address width
DATA_W, 32, data word width
DEPTH, 256, implemented words; must be <= 2**ADDR_W
MAX_BURST, 16, accesses before forced release when another client waits (>=1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
i_req  in  N_CLIENTS  per-client request/hold
i_we  in  N_CLIENTS  per-client write enable (1=write, 0=read)
i_addr  in  N_CLIENTS*ADDR_W  flattened addresses, client k at [k*ADDR_W +: ADDR_W]
i_wdata  in  N_CLIENTS*DATA_W  flattened write data, same packing
o_gnt  out  N_CLIENTS  registered one-hot grant
o_rvalid  out  N_CLIENTS  read data valid, one-hot to the reading client
o_rdata  out  DATA_W  shared read data
o_err  out  1  one-cycle pulse: out-of-range access
o_busy  out  1  1 while in BUSY state

Behaviour:
- One clock (clk); reset asynchronous, active-low (rst_n). Reset: o_gnt=0, o_rvalid=0, o_rdata=0, o_err=0, o_busy=0, state=IDLE, burst_cnt=0, last_owner=N_CLIENTS-1. RAM contents not reset.
- States: IDLE, BUSY, RELEASE.
- IDLE: if any i_req, pick winner, next edge o_gnt[w]=1, state BUSY, burst_cnt=0. No request: stay IDLE.
- BUSY, owner o: each cycle with i_req[o]=1 is one access using client o's i_we/i_addr/i_wdata; burst_cnt increments (saturates at MAX_BURST).
- Write: RAM[addr] <= wdata at that edge. Read: o_rdata=RAM[addr], o_rvalid[o]=1 on following cycle (latency 1); o_rvalid=0 otherwise. Read-after-write same address on consecutive cycles returns new data.
- Other clients' inputs ignored while not granted; never touch RAM.
- BUSY -> RELEASE when i_req[o]=0 (no access that cycle) OR (burst_cnt reaches MAX_BURST on an access AND another client's i_req=1). That access completes; o_gnt=0 from next cycle. Sole requester is never force-released.
- RELEASE: one dead cycle, last_owner=o, then IDLE. Minimum gap between grants: 2 cycles.
- Address >= DEPTH: write discarded, read returns o_rdata=0 with o_rvalid still asserted, o_err pulses the cycle the response would appear. Counts toward burst.
- o_busy=1 exactly in BUSY.
- Pending read when forced release: its o_rvalid still delivered in RELEASE cycle.
- Reset mid-burst: grant and pending o_rvalid dropped immediately; in-flight write at the same edge not guaranteed.
- i_req raised and grant issued same cycle impossible: grant always registered.

Optional Feature:
MATRIX_ARB_RR_EN: defined -> round-robin: winner is first requester scanning upward from last_owner+1 modulo N_CLIENTS. Undefined -> fixed priority, lowest index wins; last_owner still tracked but unused.

Test Plan:
- Reset release, client 0 writes addr 5=0xDEADBEEF, then reads addr 5 -> o_gnt=001 one cycle after req, o_rvalid[0] one cycle after read with o_rdata=0xDEADBEEF.
- Clients 0 and 2 request simultaneously from IDLE -> fixed priority: gnt=001; with MATRIX_ARB_RR_EN and last_owner=0: gnt=100.
- MAX_BURST=4, client 1 holds req reading addrs 0..9 while client 0 requests -> exactly 4 accesses, o_gnt=0 for 2 cycles, then gnt=001.
- MAX_BURST=4, client 1 alone reading 10 words -> no forced release, 10 rvalid pulses on o_rvalid[1].
- DEPTH=200, read addr 250 -> o_rdata=0, o_rvalid=1, o_err=1 one cycle; write addr 250 then read addr 250 mod nothing changed (RAM[50] untouched).
- Assert rst_n=0 mid-burst with read outstanding -> o_gnt, o_rvalid, o_busy zero immediately; after release first grant follows normal arbitration.
